// File: rtl/md_ctrl.sv
// HI/LO multiply/divide controller for the E stage: decodes the md group,
// runs a fixed-latency counter FSM, commits HI/LO and requests D-stage stalls.
module md_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_e,
    input  logic             valid_e,
    input  logic [31:0]      instr_d,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             start,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] md_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_div, op_sgn;

    logic [5:0] f_e, f_d;
    logic       rtype_e, e_mul, e_div, e_mthi, e_mtlo, e_mfhi, e_mflo, d_md;
    logic       last;

    assign f_e     = instr_e[5:0];
    assign f_d     = instr_d[5:0];
    assign rtype_e = (instr_e[31:26] == 6'b000000);
    assign e_mul   = rtype_e && (f_e == F_MULT || f_e == F_MULTU);
    assign e_div   = rtype_e && (f_e == F_DIV  || f_e == F_DIVU);
    assign e_mthi  = rtype_e && (f_e == F_MTHI);
    assign e_mtlo  = rtype_e && (f_e == F_MTLO);
    assign e_mfhi  = rtype_e && (f_e == F_MFHI);
    assign e_mflo  = rtype_e && (f_e == F_MFLO);
    // md group is exactly the functs of the form 01x0xx
    assign d_md    = (instr_d[31:26] == 6'b000000) && (f_d[5:4] == 2'b01) && !f_d[2];
    assign last    = (cnt == CW'(1));

    logic unused_bits;
    assign unused_bits = ^{instr_e[25:6], instr_d[25:6]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE: start = valid_e && (e_mul || e_div);
            RUN:  busy  = 1'b1;
            default: ;
        endcase
    end

    assign stall_req = (start || busy) && d_md;

    always_comb begin
        md_out = '0;
        if (e_mfhi)      md_out = hi;
        else if (e_mflo) md_out = lo;
    end

    // Results are combinational on the latched operands; only the commit edge matters.
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b, uq, ur, quo, rem;

    always_comb begin
        ext_a = op_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        ext_b = op_sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        prod  = ext_a * ext_b;
        // Sign-magnitude divide: most-negative / -1 falls out as LO=most-negative, HI=0.
        neg_a = op_sgn && op_a[WIDTH-1];
        neg_b = op_sgn && op_b[WIDTH-1];
        mag_a = neg_a ? -op_a : op_a;
        mag_b = neg_b ? -op_b : op_b;
        div_b = (mag_b == '0) ? WIDTH'(1) : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quo   = (neg_a ^ neg_b) ? -uq : uq;
        rem   = neg_a ? -ur : ur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_div <= 1'b0;
            op_sgn <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                op_a   <= rs_val;
                op_b   <= rt_val;
                op_div <= e_div;
                op_sgn <= !f_e[0];
                cnt    <= e_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            end else if (valid_e && e_mthi) begin
                hi <= rs_val;
            end else if (valid_e && e_mtlo) begin
                lo <= rs_val;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (last) begin
                if (!op_div) begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end else if (op_b != '0) begin
                    hi <= rem;
                    lo <= quo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: expected HI/LO and latency are queued at issue
// and popped when the operation's busy window closes.
module tb_md_ctrl;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_e, instr_d, rs_val, rt_val;
    logic        valid_e;
    logic        start, busy, stall_req;
    logic [31:0] md_out, hi, lo;

    md_ctrl #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .instr_e(instr_e), .valid_e(valid_e),
        .instr_d(instr_d), .rs_val(rs_val), .rt_val(rt_val), .start(start),
        .busy(busy), .stall_req(stall_req), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];
    int          lat_q[$];
    logic [31:0] eh = '0, el = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] f);
        return {6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, f};
    endfunction

    // Reference arithmetic on 64-bit integers, independent of the RTL datapath.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] oh, output logic [31:0] ol);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        oh = eh;
        ol = el;
        case (f)
            F_MULT:  begin p = 64'(sa * sb); oh = p[63:32]; ol = p[31:0]; end
            F_MULTU: begin p = {32'b0, a} * {32'b0, b}; oh = p[63:32]; ol = p[31:0]; end
            F_DIV:   if (b != 0) begin p = 64'(sa % sb); oh = p[31:0]; p = 64'(sa / sb); ol = p[31:0]; end
            F_DIVU:  if (b != 0) begin oh = a % b; ol = a / b; end
            default: ;
        endcase
    endfunction

    task automatic md_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] xh, input logic [31:0] xl);
        int n;
        logic [63:0] x;
        @(negedge clk);
        instr_e = mk(f); valid_e = 1'b1; rs_val = a; rt_val = b;
        sb_q.push_back({xh, xl});
        lat_q.push_back((f == F_DIV || f == F_DIVU) ? 10 : 5);
        eh = xh; el = xl;
        #1 chk("start", 64'(start), 64'(1));
        // same md instruction still in E while busy must be ignored
        @(negedge clk);
        #1 chk("start_once", 64'(start), 64'(0));
        instr_e = '0; valid_e = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 64'(n), 64'(lat_q.pop_front()));
        x = sb_q.pop_front();
        chk("hi", 64'(hi), 64'(x[63:32]));
        chk("lo", 64'(lo), 64'(x[31:0]));
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] v);
        @(negedge clk);
        instr_e = mk(f); valid_e = 1'b1; rs_val = v;
        @(negedge clk);
        instr_e = '0; valid_e = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, xh, xl;
        logic [5:0]  f;
        logic [5:0]  ops[4];
        ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

        reset = 1'b1; instr_e = '0; instr_d = '0; valid_e = 1'b0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;

        md_op(F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        md_op(F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        md_op(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        mt(F_MTHI, 32'h12);
        mt(F_MTLO, 32'h34);
        chk("mthi", 64'(hi), 64'(32'h12));
        chk("mtlo", 64'(lo), 64'(32'h34));
        eh = 32'h12; el = 32'h34;
        md_op(F_DIVU, 32'h00000005, 32'h00000000, 32'h12, 32'h34);

        @(negedge clk);
        instr_e = mk(F_MFHI); #1 chk("mfhi", 64'(md_out), 64'(32'h12));
        instr_e = mk(F_MFLO); #1 chk("mflo", 64'(md_out), 64'(32'h34));
        instr_e = '0;         #1 chk("md_out_0", 64'(md_out), 64'(0));

        // valid_e low: no start, no HI write
        @(negedge clk);
        instr_e = mk(F_MULT); valid_e = 1'b0; rs_val = 32'h7; rt_val = 32'h9;
        #1 chk("inv_start", 64'(start), 64'(0));
        @(negedge clk);
        chk("inv_busy", 64'(busy), 64'(0));
        instr_e = mk(F_MTHI); rs_val = 32'hDEAD;
        @(negedge clk);
        chk("inv_mthi", 64'(hi), 64'(32'h12));
        instr_e = '0;

        // stall window: div at T with mflo waiting in D
        @(negedge clk);
        instr_e = mk(F_DIV); valid_e = 1'b1; rs_val = 32'hFFFFFFF9; rt_val = 32'h2;
        instr_d = mk(F_MFLO);
        #1 chk("stall_T0", 64'(stall_req), 64'(1));
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin instr_e = '0; valid_e = 1'b0; end
            #1 chk($sformatf("stall_T%0d", k), 64'(stall_req), (k <= 10) ? 64'(1) : 64'(0));
        end
        instr_d = '0; instr_e = mk(F_MFLO); valid_e = 1'b1;
        #1 chk("mflo_quot", 64'(md_out), 64'(32'hFFFFFFFD));
        @(negedge clk);
        instr_e = '0; valid_e = 1'b0;
        eh = hi; el = lo;
        chk("div_hi", 64'(hi), 64'(32'hFFFFFFFF));

        for (int i = 0; i < 8; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom);
            model(f, a, b, xh, xl);
            md_op(f, a, b, xh, xl);
        end

        mt(F_MTHI, 32'h55);
        // reset in the third busy cycle of a div
        @(negedge clk);
        instr_e = mk(F_DIV); valid_e = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        instr_e = '0; valid_e = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        mt(F_MTHI, 32'hA5);
        chk("post_rst_mthi", 64'(hi), 64'(32'hA5));
        repeat (12) @(negedge clk);
        chk("no_late_commit", 64'(lo), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Parametrised multiply/divide controller for the pipelined MIPS core's E stage; successor to the combinational decode controller.
- Decodes the HI/LO instruction group from the E-stage instruction and runs a multi-cycle operation with a counter FSM.
- Owns the HI/LO registers and raises a stall request to the hazard unit when the D-stage instruction needs the unit while it is occupied.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_LAT, 5: busy cycles for mult/multu (>=1).
- DIV_LAT, 10: busy cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- instr_e  input  32  E-stage instruction.
- valid_e  input  1  E-stage instruction is real (0 = bubble/nop inserted by stall).
- instr_d  input  32  D-stage instruction, used for stall request.
- rs_val  input  WIDTH  forwarded rs operand in E.
- rt_val  input  WIDTH  forwarded rt operand in E.
- start  output  1  combinational; an md operation is accepted this cycle.
- busy  output  1  registered; operation in progress.
- stall_req  output  1  combinational; stall D stage.
- md_out  output  WIDTH  HI for mfhi, LO for mflo, else 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Decode requires opcode 000000. Funct values: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Reset (async): state IDLE, busy=0, counter=0, hi=0, lo=0, and all latched operands cleared.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start = valid_e & (mult|multu|div|divu).
  - On start, latch rs_val/rt_val and the op.
  - Load counter with MULT_LAT or DIV_LAT, then go to RUN.
- RUN:
  - busy=1.
  - Counter decrements each cycle.
  - In the cycle with counter==1, the edge writes HI/LO and returns to IDLE.
  - Timing: start in cycle T gives busy=1 in cycles T+1..T+LAT, and the new hi/lo is visible from T+LAT+1.
- mthi/mtlo:
  - Accepted only in IDLE with valid_e.
  - Writes rs_val to hi/lo at the next edge, with no busy.
- mfhi/mflo: md_out is combinational from the current hi/lo.
- Any md-group instruction in E while busy is ignored; stall_req guarantees this never occurs in normal operation.
- stall_req = (start | busy) & instr_d is md-group (all 8 functs).
- Arithmetic:
  - mult: signed 2WIDTH product; HI = upper half, LO = lower half.
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: same, unsigned.
  - Divisor zero (div/divu): busy runs the full DIV_LAT, and HI/LO stay unchanged.
  - Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- Result computation is free-form internally (combinational on latched operands, or iterative within LAT); only the commit timing above is observable.
- Reset asserted mid-RUN aborts the operation; hi/lo return to 0 and busy drops immediately.
- valid_e=0 never starts or writes anything, regardless of instr_e.

Test Plan:
- multu rs=0xFFFFFFFF, rt=0x00000002 → start=1 for one cycle; busy=1 for exactly 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE.
- mult rs=0xFFFFFFFD (-3), rt=5 → after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div rs=0xFFFFFFF9 (-7), rt=2 → 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu by zero with hi=0x12, lo=0x34 preloaded via mthi/mtlo → busy for 10 cycles; hi=0x12 and lo=0x34 unchanged.
- div started, then mflo in instr_d → stall_req=1 in cycles T..T+10, 0 at T+11; md_out=quotient when mflo reaches E.
- Reset asserted at cycle 3 of a div → busy=0 and hi=lo=0 immediately; a following mthi 0xA5 gives hi=0xA5.
